usb_ctrl_seq: RTL
=================

Name: usb_ctrl_seq

Overview:
Transfer sequencer for the USB serial interface engine. It tracks the control-transfer stage of endpoint 0 (SETUP, DATA, STATUS), keeps the DATA0/DATA1 toggle bits for every endpoint, and owns the per-endpoint STALL state. It tells the SIE packet FSM which data PID to send, which data PID to expect, and whether to ACK/store, ACK/discard or STALL.

Parameters:
NUM_ENDP, 2, number of implemented endpoints (1..16); endpoint numbers >= NUM_ENDP are unimplemented
DATA0_PID, 4'b0011, DATA0 PID code
DATA1_PID, 4'b1011, DATA1 PID code

Ports:
clk  in  1  24 MHz system clock
reset  in  1  asynchronous, active-high reset
tok_valid  in  1  one-cycle pulse: token addressed to this device fully received
tok_pid  in  4  token PID (OUT 0001, IN 1001, SETUP 1101), valid with tok_valid
tok_endp  in  4  token endpoint, valid with tok_valid
data_done  in  1  one-cycle pulse: host data packet received with good CRC16
data_pid  in  4  PID of that data packet, valid with data_done
setup_dir  in  1  bmRequestType[7] of the SETUP data, valid with data_done in SETUP stage
setup_wlen0  in  1  wLength==0 of the SETUP data, valid with data_done in SETUP stage
ack_rcvd  in  1  one-cycle pulse: host ACK received after a device IN data packet
sw_stall_set  in  NUM_ENDP  one-cycle per-endpoint stall request from J1 I/O
sw_toggle_clr  in  NUM_ENDP  one-cycle per-endpoint toggle reset (both directions to DATA0)
cur_endp  out  4  endpoint latched from the last tok_valid
tx_pid  out  4  data PID for the next IN packet of cur_endp (combinational from state)
exp_pid  out  4  expected data PID for OUT/SETUP data of cur_endp (combinational)
stall  out  1  respond STALL to the current token (combinational)
out_accept  out  1  registered pulse: last data_done matched exp_pid; SIE ACKs and keeps data
out_dup  out  1  registered pulse: last data_done mismatched; SIE ACKs and discards data
stage  out  3  EP0 stage: 0 IDLE, 1 SETUP, 2 DIN, 3 DOUT, 4 STAT_IN, 5 STAT_OUT
setup_evt  out  1  registered pulse: SETUP data accepted (firmware reads request)
status_done  out  1  registered pulse: control transfer completed

Behaviour:
- reset (async): state IDLE, cur_endp 0, all tog_in/tog_out 0, all ep_stall 0, proto_stall 0, all pulse outputs 0.
- tok_valid latches cur_endp <= tok_endp and cur_pid <= tok_pid.
- tx_pid = tog_in[cur_endp] ? DATA1_PID : DATA0_PID; exp_pid is the same mapping from tog_out, forced to DATA0_PID while state is SETUP.
- stall = ep_stall[cur_endp] | (cur_endp==0 & proto_stall) | (cur_endp >= NUM_ENDP). SETUP tokens to EP0 are never stalled.
- EP0 FSM. tok_valid with SETUP on endp 0, from any state, goes to SETUP; it sets tog_out[0]=0, clears ep_stall[0] and proto_stall. On the same cycle, SETUP wins over sw_stall_set[0].
- SETUP + data_done with DATA0 goes to:
  - STAT_IN if setup_wlen0=1;
  - otherwise DIN if setup_dir=1, else DOUT.
  - It sets tog_in[0]=1 and tog_out[0]=1, and pulses setup_evt. A DATA1 PID in SETUP gives out_dup, with no stage change.
- DIN: IN tokens move data; ack_rcvd flips tog_in[0]. An OUT token goes to STAT_OUT and forces tog_out[0]=1.
- DOUT: accepted OUT data flips tog_out[0]. An IN token goes to STAT_IN and forces tog_in[0]=1.
- STAT_IN: ack_rcvd goes to IDLE and pulses status_done. An OUT token sets proto_stall.
- STAT_OUT: accepted data_done goes to IDLE and pulses status_done. An IN token sets proto_stall.
- IDLE: an IN or OUT token on EP0 sets proto_stall.
- Non-zero endpoints have no stage. data_done with data_pid==exp_pid and stall=0 gives out_accept and flips tog_out[cur_endp]. Mismatch with stall=0 gives out_dup and no flip. stall=1 gives neither pulse.
- ack_rcvd flips tog_in[cur_endp] only when cur_pid was IN and stall=0.
- Priorities on the same cycle:
  - sw_toggle_clr beats ack_rcvd/data_done flips on that endpoint.
  - sw_stall_set for endp>0 sets ep_stall; it is cleared only by sw_toggle_clr of that endpoint (CLEAR_FEATURE path) or reset.
- Latency: out_accept, out_dup, setup_evt and status_done assert exactly 1 cycle after the causing input pulse, for one cycle.
- Events naming an endpoint >= NUM_ENDP change no state.
- Reset asserted mid-transfer returns everything to reset values immediately; there is no partial-stage memory.

Test Plan:
- SETUP/endp0, data_done DATA0, setup_dir=1, wlen0=0 -> setup_evt pulse next cycle, out_accept, stage=2, tx_pid=1011.
- From DIN: IN + ack_rcvd twice -> tx_pid toggles 1011->0011->1011; OUT token -> stage=5, exp_pid=1011; data_done DATA1 -> status_done, stage=0.
- Endp1 OUT with DATA0 then DATA0 again -> out_accept, then out_dup; tog_out[1]=1, exp_pid=1011.
- sw_stall_set[1] then IN on endp1 -> stall=1, ack_rcvd ignored; sw_toggle_clr[1] -> stall=0, tx_pid=0011.
- IN on EP0 in IDLE -> stall=1; then SETUP on EP0 together with sw_stall_set[0] -> stall=0, stage=1.
- Assert reset in DOUT with tog_out[0]=0 -> stage=0, all toggles 0, no pulses; token to endp 5 -> stall=1.

Source files
------------

// File: rtl/usb_ctrl_seq.sv
// Transfer sequencer for the USB SIE: EP0 control-stage FSM, per-endpoint
// DATA0/DATA1 toggles and STALL state, and data-PID / handshake decisions.
module usb_ctrl_seq #(
  parameter int unsigned NUM_ENDP  = 2,
  parameter logic [3:0]  DATA0_PID = 4'b0011,
  parameter logic [3:0]  DATA1_PID = 4'b1011
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tok_valid,
  input  logic [3:0]          tok_pid,
  input  logic [3:0]          tok_endp,
  input  logic                data_done,
  input  logic [3:0]          data_pid,
  input  logic                setup_dir,
  input  logic                setup_wlen0,
  input  logic                ack_rcvd,
  input  logic [NUM_ENDP-1:0] sw_stall_set,
  input  logic [NUM_ENDP-1:0] sw_toggle_clr,
  output logic [3:0]          cur_endp,
  output logic [3:0]          tx_pid,
  output logic [3:0]          exp_pid,
  output logic                stall,
  output logic                out_accept,
  output logic                out_dup,
  output logic [2:0]          stage,
  output logic                setup_evt,
  output logic                status_done
);

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSetup   = 3'd1,
    StDin     = 3'd2,
    StDout    = 3'd3,
    StStatIn  = 3'd4,
    StStatOut = 3'd5
  } stage_e;

  stage_e              stage_q, stage_d;
  logic [3:0]          cur_endp_q, cur_endp_d;
  logic [3:0]          cur_pid_q, cur_pid_d;
  logic [NUM_ENDP-1:0] tog_in_q, tog_in_d;
  logic [NUM_ENDP-1:0] tog_out_q, tog_out_d;
  logic [NUM_ENDP-1:0] ep_stall_q, ep_stall_d;
  logic                proto_stall_q, proto_stall_d;
  logic                out_accept_q, out_accept_d;
  logic                out_dup_q, out_dup_d;
  logic                setup_evt_q, setup_evt_d;
  logic                status_done_q, status_done_d;

  logic [NUM_ENDP-1:0] cur_sel;
  logic                ep_ok, ep0, cur_tog_in, cur_tog_out, cur_ep_stall;
  logic                setup_tok;

  // One-hot select of the latched endpoint; all-zero when it is unimplemented.
  always_comb begin
    cur_sel = '0;
    for (int i = 0; i < NUM_ENDP; i++) begin
      cur_sel[i] = (cur_endp_q == 4'(i));
    end
  end

  assign ep_ok        = |cur_sel;
  assign ep0          = (cur_endp_q == 4'd0);
  assign cur_tog_in   = |(tog_in_q & cur_sel);
  assign cur_tog_out  = |(tog_out_q & cur_sel);
  assign cur_ep_stall = |(ep_stall_q & cur_sel);

  always_comb begin
    stall = cur_ep_stall | (ep0 & proto_stall_q) | ~ep_ok;
    if (ep0 && cur_pid_q == PidSetup) begin
      stall = 1'b0;
    end
  end

  assign tx_pid  = cur_tog_in ? DATA1_PID : DATA0_PID;
  assign exp_pid = (stage_q == StSetup) ? DATA0_PID : (cur_tog_out ? DATA1_PID : DATA0_PID);

  always_comb begin
    stage_d       = stage_q;
    cur_endp_d    = cur_endp_q;
    cur_pid_d     = cur_pid_q;
    tog_in_d      = tog_in_q;
    tog_out_d     = tog_out_q;
    ep_stall_d    = ep_stall_q;
    proto_stall_d = proto_stall_q;
    out_accept_d  = 1'b0;
    out_dup_d     = 1'b0;
    setup_evt_d   = 1'b0;
    status_done_d = 1'b0;
    setup_tok     = 1'b0;

    if (tok_valid) begin
      cur_endp_d = tok_endp;
      cur_pid_d  = tok_pid;
      if (tok_endp == 4'd0) begin
        if (tok_pid == PidSetup) begin
          setup_tok     = 1'b1;
          stage_d       = StSetup;
          tog_out_d[0]  = 1'b0;
          proto_stall_d = 1'b0;
        end else if (tok_pid == PidIn) begin
          case (stage_q)
            StDout: begin
              stage_d     = StStatIn;
              tog_in_d[0] = 1'b1;
            end
            StIdle, StStatOut: proto_stall_d = 1'b1;
            default: ;
          endcase
        end else if (tok_pid == PidOut) begin
          case (stage_q)
            StDin: begin
              stage_d      = StStatOut;
              tog_out_d[0] = 1'b1;
            end
            StIdle, StStatIn: proto_stall_d = 1'b1;
            default: ;
          endcase
        end
      end
    end

    if (data_done && !stall) begin
      if (ep0 && stage_q == StSetup) begin
        if (data_pid == DATA0_PID) begin
          out_accept_d = 1'b1;
          setup_evt_d  = 1'b1;
          tog_in_d[0]  = 1'b1;
          tog_out_d[0] = 1'b1;
          stage_d      = setup_wlen0 ? StStatIn : (setup_dir ? StDin : StDout);
        end else begin
          out_dup_d = 1'b1;
        end
      end else if (data_pid == exp_pid) begin
        out_accept_d = 1'b1;
        tog_out_d    = tog_out_d ^ cur_sel;
        if (ep0 && stage_q == StStatOut) begin
          stage_d       = StIdle;
          status_done_d = 1'b1;
        end
      end else begin
        out_dup_d = 1'b1;
      end
    end

    if (ack_rcvd && cur_pid_q == PidIn && !stall) begin
      tog_in_d = tog_in_d ^ cur_sel;
      if (ep0 && stage_q == StStatIn) begin
        stage_d       = StIdle;
        status_done_d = 1'b1;
      end
    end

    // Toggle clear is the CLEAR_FEATURE path: it lifts the stall and wins over flips.
    ep_stall_d = (ep_stall_d & ~sw_toggle_clr) | sw_stall_set;
    if (setup_tok) begin
      ep_stall_d[0] = 1'b0;
    end
    tog_in_d  = tog_in_d & ~sw_toggle_clr;
    tog_out_d = tog_out_d & ~sw_toggle_clr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_q       <= StIdle;
      cur_endp_q    <= 4'd0;
      cur_pid_q     <= 4'd0;
      tog_in_q      <= '0;
      tog_out_q     <= '0;
      ep_stall_q    <= '0;
      proto_stall_q <= 1'b0;
      out_accept_q  <= 1'b0;
      out_dup_q     <= 1'b0;
      setup_evt_q   <= 1'b0;
      status_done_q <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      cur_endp_q    <= cur_endp_d;
      cur_pid_q     <= cur_pid_d;
      tog_in_q      <= tog_in_d;
      tog_out_q     <= tog_out_d;
      ep_stall_q    <= ep_stall_d;
      proto_stall_q <= proto_stall_d;
      out_accept_q  <= out_accept_d;
      out_dup_q     <= out_dup_d;
      setup_evt_q   <= setup_evt_d;
      status_done_q <= status_done_d;
    end
  end

  assign cur_endp    = cur_endp_q;
  assign stage       = stage_q;
  assign out_accept  = out_accept_q;
  assign out_dup     = out_dup_q;
  assign setup_evt   = setup_evt_q;
  assign status_done = status_done_q;

endmodule
